// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: recovers pixel position from incoming syncs, checks line/frame timing,
// locks to the stream and reports a per-frame RGB checksum plus a single-pixel probe.
module vga_frame_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_LOW    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic        video_on,
  output logic [9:0]  x_loc,
  output logic [9:0]  y_loc,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [11:0] probe_rgb,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
  localparam logic [9:0]  H_SYNC_L  = 10'(H_SYNC);
  localparam logic [9:0]  V_SYNC_L  = 10'(V_SYNC);
  localparam logic [9:0]  H_FIRST   = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_LAST    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_LAST    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;
  localparam logic [7:0]  LOCK_GOAL = 8'(LOCK_FRAMES);
  localparam logic [7:0]  ERR_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        hs_act;
  logic        vs_act;
  logic        hs_prev;
  logic        vs_prev;
  logic        h_rise;
  logic        h_fall;
  logic        v_rise;
  logic        v_fall;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_cnt_nxt;
  logic [9:0]  v_cnt_nxt;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic        in_active;

  logic        checking;
  logic        h_bad;
  logic        v_bad;
  logic        any_err;

  logic [7:0]  good_cnt;
  logic        frame_bad;
  logic [15:0] acc;
  logic [11:0] pix_rgb;

  // Normalise both syncs to active-high so edge detection is polarity independent.
  assign hs_act  = (SYNC_LOW != 0) ? ~h_sync : h_sync;
  assign vs_act  = (SYNC_LOW != 0) ? ~v_sync : v_sync;
  assign pix_rgb = {red, green, blue};

  assign h_rise = pix_en &  hs_act & ~hs_prev;
  assign h_fall = pix_en & ~hs_act &  hs_prev;
  assign v_rise = pix_en &  vs_act & ~vs_prev;
  assign v_fall = pix_en & ~vs_act &  vs_prev;

  // Position of the current sample; saturating so a lost sync never wraps into a fake position.
  always_comb begin
    h_cnt_nxt = h_cnt;
    if (h_rise) begin
      h_cnt_nxt = '0;
    end else if (h_cnt != CNT_MAX) begin
      h_cnt_nxt = h_cnt + 10'd1;
    end

    v_cnt_nxt = v_cnt;
    if (v_rise) begin
      v_cnt_nxt = '0;
    end else if (h_rise && (v_cnt != CNT_MAX)) begin
      v_cnt_nxt = v_cnt + 10'd1;
    end
  end

  assign in_active = (h_cnt_nxt >= H_FIRST) && (h_cnt_nxt <= H_LAST) &&
                     (v_cnt_nxt >= V_FIRST) && (v_cnt_nxt <= V_LAST);
  assign x_nxt     = h_cnt_nxt - H_FIRST;
  assign y_nxt     = v_cnt_nxt - V_FIRST;

  // Sync widths are measured as the count reached on the deassert sample.
  assign checking = (state != SEARCH);
  assign h_bad    = checking &&
                    ((h_rise && (({1'b0, h_cnt} + 11'd1) != H_TOTAL_L)) ||
                     (h_fall && (h_cnt_nxt != H_SYNC_L)));
  assign v_bad    = checking &&
                    ((v_rise && (({1'b0, v_cnt} + 11'd1) != V_TOTAL_L)) ||
                     (v_fall && (v_cnt_nxt != V_SYNC_L)));
  assign any_err  = h_bad || v_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (pix_en) begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Locking is decided only at frame boundaries; any violation while locked drops straight back.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (v_rise) begin
          state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (v_rise && !any_err && !frame_bad && (good_cnt == LOCK_GOAL)) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt  <= '0;
      frame_bad <= 1'b0;
    end else if (pix_en) begin
      if (v_rise) begin
        frame_bad <= 1'b0;
      end else if (any_err && (state == ACQUIRE)) begin
        frame_bad <= 1'b1;
      end

      if ((state == SEARCH) && v_rise) begin
        good_cnt <= '0;
      end else if (state == ACQUIRE) begin
        if (any_err || (v_rise && frame_bad)) begin
          good_cnt <= '0;
        end else if (v_rise && (good_cnt != LOCK_GOAL)) begin
          good_cnt <= good_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_err     <= 1'b0;
      v_err     <= 1'b0;
      err_count <= '0;
    end else begin
      h_err <= h_bad;
      v_err <= v_bad;
      if ((state == LOCKED) && any_err && (err_count != ERR_MAX)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on <= 1'b0;
      x_loc    <= '0;
      y_loc    <= '0;
    end else if (pix_en) begin
      video_on <= in_active;
      x_loc    <= in_active ? x_nxt : 10'd0;
      y_loc    <= in_active ? y_nxt : 10'd0;
    end
  end

  // A checksum is only published for frames that started while we were already tracking the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pix_en) begin
        if (v_rise) begin
          acc <= '0;
          if (state != SEARCH) begin
            frame_sum  <= acc;
            frame_done <= 1'b1;
          end
        end else if (in_active) begin
          acc <= acc + {4'd0, pix_rgb};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_rgb <= '0;
    end else if (pix_en && in_active && (x_nxt == probe_x) && (y_nxt == probe_y)) begin
      probe_rgb <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a shrunken raster (10x7 totals, 6x3 active)
// so that lock, relock and error-count saturation scenarios fit in a short run.
module tb_vga_frame_monitor;

  localparam int H_ACTIVE    = 6;
  localparam int H_FP        = 1;
  localparam int H_SYNC      = 2;
  localparam int H_BP        = 1;
  localparam int V_ACTIVE    = 3;
  localparam int V_FP        = 1;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 1;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TOTAL     = 10;
  localparam int V_TOTAL     = 7;
  localparam int H_FIRST     = 3;
  localparam int H_LAST      = 8;
  localparam int V_FIRST     = 3;
  localparam int V_LAST      = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic        h_sync;
  logic        v_sync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [9:0]  probe_x;
  logic [9:0]  probe_y;
  logic        locked;
  logic        video_on;
  logic [9:0]  x_loc;
  logic [9:0]  y_loc;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [11:0] probe_rgb;
  logic        h_err;
  logic        v_err;
  logic [7:0]  err_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          gap = 1;
  int          h_err_seen;
  int          v_err_seen;
  int          fd_seen;
  int          video_seen;
  int          pulse_stuck = 0;
  logic [15:0] last_sum;
  logic        locked_at_err;
  bit          chk_pos = 1'b0;

  always #5 clk = ~clk;

  vga_frame_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_LOW(1), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue), .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .video_on(video_on), .x_loc(x_loc), .y_loc(y_loc),
    .frame_done(frame_done), .frame_sum(frame_sum), .probe_rgb(probe_rgb),
    .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounts();
    h_err_seen = 0;
    v_err_seen = 0;
    fd_seen    = 0;
    video_seen = 0;
  endtask

  // One pixel strobe; syncs given as active levels, driven active-low on the pins.
  task automatic applyStimulus(input logic hs_a, input logic vs_a, input logic [11:0] rgb);
    @(negedge clk);
    h_sync = ~hs_a;
    v_sync = ~vs_a;
    {red, green, blue} = rgb;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    if (h_err) begin
      h_err_seen++;
      locked_at_err = locked;
    end
    if (v_err) v_err_seen++;
    if (frame_done) begin
      fd_seen++;
      last_sum = frame_sum;
    end
    if (video_on) video_seen++;
    repeat (gap) begin
      @(posedge clk);
      #1;
      if (h_err || v_err || frame_done) pulse_stuck++;
    end
  endtask

  function automatic logic [11:0] pixColor(input int mode, input int l, input int h);
    int x;
    int y;
    x = h - H_FIRST;
    y = l - V_FIRST;
    if (h < H_FIRST || h > H_LAST || l < V_FIRST || l > V_LAST) return 12'h777;
    case (mode)
      0:       return 12'h001;
      1:       return {4'(x), 4'(y), 4'h0};
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic sendFrame(input int mode, input int short_line, input int vs_lines);
    for (int l = 0; l < V_TOTAL; l++) begin
      int len;
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        applyStimulus(h < H_SYNC, l < vs_lines, pixColor(mode, l, h));
        if (chk_pos) begin
          if (l == V_FIRST && h == H_FIRST - 1) checkOutput("video_before_first", video_on, 0);
          if (l == V_FIRST && h == H_FIRST) begin
            checkOutput("video_first", video_on, 1);
            checkOutput("x_first", x_loc, 0);
            checkOutput("y_first", y_loc, 0);
          end
          if (l == V_LAST && h == H_LAST) begin
            checkOutput("x_last", x_loc, 5);
            checkOutput("y_last", y_loc, 2);
          end
          if (l == V_LAST && h == H_LAST + 1) checkOutput("video_hfp", video_on, 0);
          if (l == V_LAST + 1 && h == H_FIRST) checkOutput("video_vfp", video_on, 0);
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    pix_en = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    {red, green, blue} = 12'h000;
    probe_x = 10'd4;
    probe_y = 10'd2;
    last_sum = '0;
    locked_at_err = 1'b1;
    clearCounts();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_video_on", video_on, 0);
    checkOutput("rst_frame_sum", frame_sum, 0);
    checkOutput("rst_probe_rgb", probe_rgb, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_pulses", {h_err, v_err, frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] nominal stream, all pixels 0x001");
    repeat (3) sendFrame(0, -1, V_SYNC);
    checkOutput("locked_after_3_edges", locked, 0);
    checkOutput("frame_done_count", fd_seen, 2);
    checkOutput("frame_sum_ones", last_sum, 16'h0012);
    checkOutput("probe_ones", probe_rgb, 12'h001);
    chk_pos = 1'b1;
    sendFrame(1, -1, V_SYNC);
    chk_pos = 1'b0;
    checkOutput("locked_at_edge_4", locked, 1);
    checkOutput("nominal_h_err", h_err_seen, 0);
    checkOutput("nominal_v_err", v_err_seen, 0);
    checkOutput("probe_gradient", probe_rgb, 12'h420);

    $display("[TB] out-of-range probe and checksum wrap");
    probe_x = 10'd7;
    sendFrame(2, -1, V_SYNC);
    checkOutput("frame_sum_gradient", last_sum, 16'h2E20);
    checkOutput("probe_hold", probe_rgb, 12'h420);
    clearCounts();
    sendFrame(0, 4, V_SYNC);
    checkOutput("frame_sum_wrap", last_sum, 16'h1FEE);

    $display("[TB] short line while locked");
    checkOutput("short_h_err", h_err_seen, 1);
    checkOutput("short_v_err", v_err_seen, 0);
    checkOutput("locked_at_h_err", locked_at_err, 0);
    checkOutput("short_err_count", err_count, 1);
    clearCounts();
    sendFrame(0, -1, V_SYNC);
    checkOutput("no_done_from_search", fd_seen, 0);
    repeat (2) sendFrame(0, -1, V_SYNC);
    checkOutput("relock_not_yet", locked, 0);
    sendFrame(0, -1, V_SYNC);
    checkOutput("relock_after_3_good", locked, 1);
    checkOutput("relock_done_count", fd_seen, 3);
    checkOutput("relock_errs", h_err_seen + v_err_seen, 0);

    $display("[TB] vsync three lines wide");
    clearCounts();
    sendFrame(0, -1, 3);
    checkOutput("wide_v_err", v_err_seen, 1);
    checkOutput("wide_h_err", h_err_seen, 0);
    checkOutput("wide_locked", locked, 0);
    checkOutput("wide_err_count", err_count, 2);

    $display("[TB] reset mid-line");
    for (int h = 0; h < 5; h++) applyStimulus(h < H_SYNC, 1'b1, 12'h777);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_err_count", err_count, 0);
    checkOutput("async_frame_sum", frame_sum, 0);
    checkOutput("async_probe_rgb", probe_rgb, 0);
    checkOutput("async_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) sendFrame(0, -1, V_SYNC);
    checkOutput("post_reset_3_edges", locked, 0);
    sendFrame(0, -1, V_SYNC);
    checkOutput("post_reset_lock", locked, 1);

    $display("[TB] repeated errors saturate err_count");
    gap = 0;
    for (int i = 0; i < 258; i++) begin
      sendFrame(0, 4, V_SYNC);
      repeat (3) sendFrame(0, -1, V_SYNC);
      if (i == 199) checkOutput("err_count_200", err_count, 200);
    end
    checkOutput("err_count_sat", err_count, 255);

    $display("[TB] hsync lost mid-frame");
    for (int l = 0; l < 5; l++)
      for (int h = 0; h < H_TOTAL; h++) applyStimulus(h < H_SYNC, l < V_SYNC, pixColor(0, l, h));
    checkOutput("locked_before_loss", locked, 1);
    clearCounts();
    for (int k = 0; k < 1100; k++) applyStimulus(1'b0, 1'b0, 12'h777);
    checkOutput("no_wrap_video", video_seen, 0);
    clearCounts();
    sendFrame(0, -1, V_SYNC);
    checkOutput("lost_h_err", h_err_seen, 1);
    checkOutput("lost_v_err", v_err_seen, 1);
    checkOutput("lost_locked", locked_at_err, 0);
    checkOutput("lost_err_count", err_count, 255);
    checkOutput("pulse_width", pulse_stuck, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
